fft_frame_scheduler: RTL and testbench

- Time-shares one radix-2 streaming FFT engine between NUM_ANT antenna receive buffers.
- Round-robin picks one antenna with a complete frame ready, then streams its N samples into the engine as N/2 two-sample beats.
- Records the antenna ID of every in-flight frame and tags each FFT result frame with the antenna it came from.
- Sits between the per-antenna sample FIFOs and the FFT engine input; also watches the engine's out_valid.

---
 rtl/fft_frame_scheduler_pkg.sv | 44 ++++
 rtl/fft_frame_scheduler_tag_fifo.sv | 83 ++++++++
 rtl/fft_frame_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and helpers for the FFT frame scheduler and its tag FIFO.
//   complex_product_t : one complex sample (signed real/imag halves)
//   sched_state_t     : scheduler FSM states
//   rr_pick()         : round-robin winner search over up to MAX_ANT requesters
package fft_frame_scheduler_pkg;

  localparam int MAX_ANT   = 8;
  localparam int ANT_IDX_W = 3;
  localparam int SAMPLE_W  = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } complex_product_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } sched_state_t;

  // Returns the first set request bit at or after ptr, wrapping at numAnt.
  // Callers must only use the result when at least one request bit is set.
  function automatic logic [ANT_IDX_W-1:0] rr_pick(
    input logic [MAX_ANT-1:0]   req,
    input logic [ANT_IDX_W-1:0] ptr,
    input int                   numAnt
  );
    logic [ANT_IDX_W-1:0] winner;
    logic                 found;
    int                   idx;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < MAX_ANT; i++) begin
      idx = (int'(ptr) + i) % numAnt;
      if (!found && (i < numAnt) && req[idx]) begin
        winner = idx[ANT_IDX_W-1:0];
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_tag_fifo.sv
// Small synchronous FIFO used to remember which source produced each
// in-flight frame. Show-ahead read: dout always presents the head entry.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears contents too)
//   push, din  : write din on push; ignored when full
//   pop        : drop the head entry; ignored when empty
//   dout       : head entry
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign doPush = push && (count_q != DEPTH_CNT);
  assign doPop  = pop && (count_q != '0);

  // Pointer wrap and occupancy bookkeeping; a simultaneous push and pop
  // leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = (wrPtr_q == LAST_IDX) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == LAST_IDX) ? '0 : rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) begin
        mem_q[wrPtr_q] <= din;
      end
    end
  end

  assign dout  = mem_q[rdPtr_q];
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one two-sample-per-beat streaming FFT engine between NUM_ANT
// antenna buffers. A round-robin arbiter picks an antenna holding a full
// frame, streams N/2 sample pairs into the engine through one register
// stage, then idles MIN_GAP cycles. Each issued frame's antenna index is
// queued so every engine result frame can be tagged with its origin.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   src_frame_rdy       : per-antenna "full frame available"
//   src_data_0/1        : per-antenna even/odd sample (first-word-fall-through)
//   src_pop             : one-hot pop of the granted antenna
//   fft_enable          : beat valid into the engine
//   fft_data_0/1        : even/odd sample into the engine
//   fft_out_valid       : engine result-frame strobe
//   out_ant_id          : antenna tag of the oldest in-flight frame
//   out_tag_valid       : fft_out_valid qualified by tag availability
//   busy                : not idle, or frames still in flight
//   tag_err             : sticky, result arrived with no tag queued
module fft_frame_scheduler
  import fft_frame_scheduler_pkg::*;
#(
  parameter int N            = 64,
  parameter int NUM_ANT      = 4,
  parameter int MIN_GAP      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ANT-1:0]         src_frame_rdy,
  input  complex_product_t           src_data_0 [NUM_ANT],
  input  complex_product_t           src_data_1 [NUM_ANT],
  output logic [NUM_ANT-1:0]         src_pop,
  output logic                       fft_enable,
  output complex_product_t           fft_data_0,
  output complex_product_t           fft_data_1,
  input  logic                       fft_out_valid,
  output logic [$clog2(NUM_ANT)-1:0] out_ant_id,
  output logic                       out_tag_valid,
  output logic                       busy,
  output logic                       tag_err
);

  localparam int ANT_W  = $clog2(NUM_ANT);
  localparam int BEAT_W = $clog2(N / 2);
  localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int CNT_W  = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N / 2 - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INFLIGHT);

  sched_state_t         state_q, state_d;
  logic [ANT_W-1:0]     rrPtr_q, rrPtr_d;
  logic [ANT_W-1:0]     grant_q, grant_d;
  logic [BEAT_W-1:0]    beatCnt_q, beatCnt_d;
  logic [GAP_W-1:0]     gapCnt_q, gapCnt_d;
  logic                 fftEnable_q;
  complex_product_t     fftData0_q, fftData1_q;
  logic                 tagErr_q;

  logic [MAX_ANT-1:0]   reqExt;
  logic [ANT_IDX_W-1:0] ptrExt;
  logic [ANT_IDX_W-1:0] winnerExt;
  logic [ANT_W-1:0]     winner;
  logic [ANT_W-1:0]     nextPtr;

  logic                 tagPush;
  logic                 tagPop;
  logic [ANT_W-1:0]     tagHead;
  logic                 tagFull;
  logic                 tagEmpty;
  logic [CNT_W-1:0]     inflightCnt;

  // Round-robin candidate, computed every cycle but only acted on in IDLE.
  always_comb begin
    reqExt                 = '0;
    reqExt[NUM_ANT-1:0]    = src_frame_rdy;
    ptrExt                 = '0;
    ptrExt[ANT_W-1:0]      = rrPtr_q;
    winnerExt              = rr_pick(reqExt, ptrExt, NUM_ANT);
    winner                 = winnerExt[ANT_W-1:0];
    nextPtr                = (int'(winner) == NUM_ANT - 1) ? '0 : winner + ANT_W'(1);
  end

  // Scheduler FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      beatCnt_q <= '0;
      gapCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      beatCnt_q <= beatCnt_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  // Next-state logic. src_pop comes only from registered state, so it never
  // depends on src_frame_rdy in the same cycle. The pop is suppressed while
  // reset is asserted so an abandoned frame loses no further samples.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    beatCnt_d = beatCnt_q;
    gapCnt_d  = gapCnt_q;
    tagPush   = 1'b0;
    src_pop   = '0;
    case (state_q)
      IDLE: begin
        if ((|src_frame_rdy) && (inflightCnt < MAX_CNT)) begin
          grant_d   = winner;
          rrPtr_d   = nextPtr;
          tagPush   = 1'b1;
          beatCnt_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (!reset) begin
          src_pop[grant_q] = 1'b1;
        end
        if (beatCnt_q == LAST_BEAT) begin
          beatCnt_d = '0;
          gapCnt_d  = '0;
          state_d   = (MIN_GAP == 0) ? IDLE : GAP;
        end else begin
          beatCnt_d = beatCnt_q + BEAT_W'(1);
        end
      end
      GAP: begin
        if (gapCnt_q == LAST_GAP) begin
          gapCnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One register stage between the popped FIFO head and the engine input;
  // data is forced to zero between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      fftEnable_q <= 1'b0;
      fftData0_q  <= '0;
      fftData1_q  <= '0;
    end else begin
      fftEnable_q <= (state_q == STREAM);
      if (state_q == STREAM) begin
        fftData0_q <= src_data_0[grant_q];
        fftData1_q <= src_data_1[grant_q];
      end else begin
        fftData0_q <= '0;
        fftData1_q <= '0;
      end
    end
  end

  assign tagPop = fft_out_valid && !tagEmpty;

  tag_fifo #(
    .WIDTH (ANT_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tagPush),
    .din   (grant_d),
    .pop   (tagPop),
    .dout  (tagHead),
    .full  (tagFull),
    .empty (tagEmpty),
    .count (inflightCnt)
  );

  // A result with no queued tag means the engine and scheduler disagree on
  // frame count; remember it until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tagErr_q <= 1'b0;
    end else if (fft_out_valid && tagEmpty) begin
      tagErr_q <= 1'b1;
    end
  end

  assign fft_enable    = fftEnable_q;
  assign fft_data_0    = fftData0_q;
  assign fft_data_1    = fftData1_q;
  assign out_ant_id    = tagHead;
  assign out_tag_valid = tagPop;
  assign busy          = (state_q != IDLE) || (inflightCnt != '0) || tagFull;
  assign tag_err       = tagErr_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (N=8, 4 antennas, MIN_GAP=2,
// two frames in flight): reset values, a cycle-exact vector table, directed
// arbitration/reset sequences, then randomized traffic against a frame-level
// reference model.
module tb_fft_frame_scheduler;
  import fft_frame_scheduler_pkg::*;

  localparam int N       = 8;
  localparam int NUM_ANT = 4;
  localparam int MIN_GAP = 2;
  localparam int MAX_INF = 2;
  localparam int ROWS    = 29;

  logic             clk;
  logic             reset;
  logic [3:0]       src_frame_rdy;
  complex_product_t src_data_0 [NUM_ANT];
  complex_product_t src_data_1 [NUM_ANT];
  logic [3:0]       src_pop;
  logic             fft_enable;
  complex_product_t fft_data_0;
  complex_product_t fft_data_1;
  logic             fft_out_valid;
  logic [1:0]       out_ant_id;
  logic             out_tag_valid;
  logic             busy;
  logic             tag_err;

  int testsRun;
  int testsFailed;

  fft_frame_scheduler #(
    .N            (N),
    .NUM_ANT      (NUM_ANT),
    .MIN_GAP      (MIN_GAP),
    .MAX_INFLIGHT (MAX_INF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_frame_rdy (src_frame_rdy),
    .src_data_0    (src_data_0),
    .src_data_1    (src_data_1),
    .src_pop       (src_pop),
    .fft_enable    (fft_enable),
    .fft_data_0    (fft_data_0),
    .fft_data_1    (fft_data_1),
    .fft_out_valid (fft_out_valid),
    .out_ant_id    (out_ant_id),
    .out_tag_valid (out_tag_valid),
    .busy          (busy),
    .tag_err       (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle vector: inputs followed by expected outputs.
  typedef struct {
    logic [3:0] rdy;
    logic       fov;
    logic [3:0] pop;
    logic       en;
    logic       tv;
    logic [1:0] id;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl [ROWS];

  // Reference model state: frame-level timeline plus a tag queue.
  int               mCyc;
  int               mGrantCycle;
  int               mGrantAnt;
  int               mNextOk;
  int               mPtr;
  int               mTagQ [$];
  bit               mErr;
  bit               mEn;
  complex_product_t mD0;
  complex_product_t mD1;

  task automatic setRow(input int i, input int rdy, input int fov, input int pop,
                        input int en, input int tv, input int id, input int bsy,
                        input int err);
    tbl[i].rdy  = 4'(rdy);
    tbl[i].fov  = 1'(fov);
    tbl[i].pop  = 4'(pop);
    tbl[i].en   = 1'(en);
    tbl[i].tv   = 1'(tv);
    tbl[i].id   = 2'(id);
    tbl[i].busy = 1'(bsy);
    tbl[i].err  = 1'(err);
  endtask

  task automatic applyStimulus(input logic [3:0] rdy, input logic fov, input logic rst);
    src_frame_rdy = rdy;
    fft_out_valid = fov;
    reset         = rst;
    for (int a = 0; a < NUM_ANT; a++) begin
      src_data_0[a] = complex_product_t'($urandom);
      src_data_1[a] = complex_product_t'($urandom);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int onehotIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] modelPop();
    if (mGrantCycle >= 0 && mCyc > mGrantCycle && mCyc <= mGrantCycle + N / 2) begin
      return 4'(1 << mGrantAnt);
    end
    return 4'b0000;
  endfunction

  task automatic modelReset();
    mGrantCycle = -1;
    mGrantAnt   = 0;
    mNextOk     = 0;
    mPtr        = 0;
    mTagQ.delete();
    mErr        = 1'b0;
    mEn         = 1'b0;
    mD0         = '0;
    mD1         = '0;
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic modelEdge();
    logic [3:0] pop;
    bit         grant;
    int         win;
    pop   = modelPop();
    grant = 1'b0;
    win   = 0;
    mEn   = (pop != 4'b0000);
    if (mEn) begin
      mD0 = src_data_0[mGrantAnt];
      mD1 = src_data_1[mGrantAnt];
    end
    if (mCyc >= mNextOk && src_frame_rdy != 4'b0000 && mTagQ.size() < MAX_INF) begin
      for (int i = NUM_ANT - 1; i >= 0; i--) begin
        if (src_frame_rdy[(mPtr + i) % NUM_ANT]) win = (mPtr + i) % NUM_ANT;
      end
      grant = 1'b1;
    end
    if (fft_out_valid) begin
      if (mTagQ.size() == 0) mErr = 1'b1;
      else void'(mTagQ.pop_front());
    end
    if (grant) begin
      mTagQ.push_back(win);
      mGrantCycle = mCyc;
      mGrantAnt   = win;
      mNextOk     = mCyc + N / 2 + MIN_GAP + 1;
      mPtr        = (win + 1) % NUM_ANT;
    end
    mCyc++;
  endtask

  // Runs 42 cycles with a result strobe every 7th cycle and records the
  // antenna of each new frame (first pop cycle) and each tagged result.
  task automatic collectGrants(input logic [3:0] rdyFirst, input logic [3:0] rdyRest,
                               output int grants [6], output int nGrants,
                               output int tags [6], output int nTags);
    logic [3:0] prevPop;
    prevPop = 4'b0000;
    nGrants = 0;
    nTags   = 0;
    for (int i = 0; i < 6; i++) begin
      grants[i] = -1;
      tags[i]   = -1;
    end
    for (int k = 0; k < 42; k++) begin
      applyStimulus((nGrants == 0) ? rdyFirst : rdyRest, 1'((k % 7) == 6), 1'b0);
      @(negedge clk);
      if (src_pop != 4'b0000 && prevPop == 4'b0000 && nGrants < 6) begin
        grants[nGrants] = onehotIdx(src_pop);
        nGrants++;
      end
      if (out_tag_valid && nTags < 6) begin
        tags[nTags] = int'(out_ant_id);
        nTags++;
      end
      prevPop = src_pop;
      tick();
    end
  endtask

  initial begin
    int         grants [6];
    int         tags [6];
    int         nGrants;
    int         nTags;
    int         expFair [6];
    int         expWrap [6];
    logic [3:0] rdy;
    logic       fov;
    logic       rst;
    bit         expTv;

    testsRun    = 0;
    testsFailed = 0;
    mCyc        = 0;
    modelReset();

    // rdy, fov | pop, en, tv, id, busy, err
    setRow( 0, 4, 0, 0, 0, 0, 0, 0, 0);
    setRow( 1, 4, 0, 4, 0, 0, 0, 1, 0);
    setRow( 2, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow( 3, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow( 4, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow( 5, 4, 0, 0, 1, 0, 0, 1, 0);
    setRow( 6, 4, 0, 0, 0, 0, 0, 1, 0);
    setRow( 7, 4, 0, 0, 0, 0, 0, 1, 0);
    setRow( 8, 4, 0, 4, 0, 0, 0, 1, 0);
    setRow( 9, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow(10, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow(11, 4, 0, 4, 1, 0, 0, 1, 0);
    setRow(12, 4, 0, 0, 1, 0, 0, 1, 0);
    setRow(13, 4, 0, 0, 0, 0, 0, 1, 0);
    setRow(14, 4, 0, 0, 0, 0, 0, 1, 0);
    setRow(15, 4, 0, 0, 0, 0, 0, 1, 0);
    setRow(16, 4, 1, 0, 0, 1, 2, 1, 0);
    setRow(17, 8, 1, 0, 0, 1, 2, 1, 0);
    setRow(18, 0, 0, 8, 0, 0, 0, 1, 0);
    setRow(19, 0, 0, 8, 1, 0, 0, 1, 0);
    setRow(20, 0, 0, 8, 1, 0, 0, 1, 0);
    setRow(21, 0, 0, 8, 1, 0, 0, 1, 0);
    setRow(22, 0, 0, 0, 1, 0, 0, 1, 0);
    setRow(23, 0, 0, 0, 0, 0, 0, 1, 0);
    setRow(24, 0, 1, 0, 0, 1, 3, 1, 0);
    setRow(25, 0, 0, 0, 0, 0, 0, 0, 0);
    setRow(26, 0, 1, 0, 0, 0, 0, 0, 0);
    setRow(27, 0, 0, 0, 0, 0, 0, 0, 1);
    setRow(28, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset values, sampled while reset is still held.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_pop",   32'(src_pop), 32'h0);
    checkOutput("reset_en",    32'(fft_enable), 32'h0);
    checkOutput("reset_data0", 32'(fft_data_0), 32'h0);
    checkOutput("reset_data1", 32'(fft_data_1), 32'h0);
    checkOutput("reset_tv",    32'(out_tag_valid), 32'h0);
    checkOutput("reset_id",    32'(out_ant_id), 32'h0);
    checkOutput("reset_busy",  32'(busy), 32'h0);
    checkOutput("reset_err",   32'(tag_err), 32'h0);
    tick();

    // Vector table: single requester, back-pressure, simultaneous push/pop,
    // then a result with an empty tag queue.
    for (int r = 0; r < ROWS; r++) begin
      applyStimulus(tbl[r].rdy, tbl[r].fov, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("row%0d_pop", r),  32'(src_pop), 32'(tbl[r].pop));
      checkOutput($sformatf("row%0d_en", r),   32'(fft_enable), 32'(tbl[r].en));
      checkOutput($sformatf("row%0d_tv", r),   32'(out_tag_valid), 32'(tbl[r].tv));
      if (tbl[r].tv) begin
        checkOutput($sformatf("row%0d_id", r), 32'(out_ant_id), 32'(tbl[r].id));
      end
      checkOutput($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      checkOutput($sformatf("row%0d_err", r),  32'(tag_err), 32'(tbl[r].err));
      tick();
    end

    // Fairness: all antennas ready -> 0,1,2,3,0,1 and tags in the same order.
    expFair = '{0, 1, 2, 3, 0, 1};
    doReset();
    collectGrants(4'b1111, 4'b1111, grants, nGrants, tags, nTags);
    checkOutput("fair_ngrants", 32'(nGrants), 32'd6);
    checkOutput("fair_ntags",   32'(nTags), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(expFair[i]));
      checkOutput($sformatf("fair_tag%0d", i),   32'(tags[i]), 32'(expFair[i]));
    end

    // Wrap and skip: pointer lands on 3, only antennas 0 and 1 then request.
    expWrap = '{2, 0, 1, 0, 1, 0};
    doReset();
    collectGrants(4'b0100, 4'b0011, grants, nGrants, tags, nTags);
    checkOutput("wrap_ngrants", 32'(nGrants), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("wrap_grant%0d", i), 32'(grants[i]), 32'(expWrap[i]));
    end

    // Reset during beat 2 of a frame from antenna 1.
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_beat0_pop", 32'(src_pop), 32'h2);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_pop_in_reset", 32'(src_pop), 32'h0);
    tick();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_pop",   32'(src_pop), 32'h0);
    checkOutput("midrst_en",    32'(fft_enable), 32'h0);
    checkOutput("midrst_data0", 32'(fft_data_0), 32'h0);
    checkOutput("midrst_data1", 32'(fft_data_1), 32'h0);
    checkOutput("midrst_tv",    32'(out_tag_valid), 32'h0);
    checkOutput("midrst_busy",  32'(busy), 32'h0);
    checkOutput("midrst_err",   32'(tag_err), 32'h0);
    tick();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_next_grant", 32'(src_pop), 32'h1);
    tick();

    // Randomized traffic against the reference model.
    doReset();
    modelReset();
    for (int k = 0; k < 800; k++) begin
      rst = 1'($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      fov = 1'($urandom_range(0, 6) == 0);
      applyStimulus(rdy, fov, rst);
      @(negedge clk);
      if (!rst) begin
        expTv = fov && (mTagQ.size() > 0);
        checkOutput($sformatf("rnd%0d_pop", k), 32'(src_pop), 32'(modelPop()));
        checkOutput($sformatf("rnd%0d_en", k),  32'(fft_enable), 32'(mEn));
        if (mEn) begin
          checkOutput($sformatf("rnd%0d_data0", k), 32'(fft_data_0), 32'(mD0));
          checkOutput($sformatf("rnd%0d_data1", k), 32'(fft_data_1), 32'(mD1));
        end
        checkOutput($sformatf("rnd%0d_tv", k), 32'(out_tag_valid), 32'(expTv));
        if (expTv) begin
          checkOutput($sformatf("rnd%0d_id", k), 32'(out_ant_id), 32'(mTagQ[0]));
        end
        checkOutput($sformatf("rnd%0d_busy", k), 32'(busy),
                    32'((mCyc < mNextOk) || (mTagQ.size() != 0)));
        checkOutput($sformatf("rnd%0d_err", k), 32'(tag_err), 32'(mErr));
      end
      @(posedge clk);
      if (rst) modelReset();
      else modelEdge();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
